// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit ALU golden checker: op codes, compare-mask
// bit positions and the flag/vector record types.
package alu8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Bit positions within CHECK_MASK.
  localparam int unsigned MASK_RESULT   = 3;
  localparam int unsigned MASK_CARRY    = 2;
  localparam int unsigned MASK_ZERO     = 1;
  localparam int unsigned MASK_OVERFLOW = 0;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu8_flags_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } alu8_vec_t;

endpackage

// File: rtl/alu_8bit_golden_model.sv
// Combinational reference ALU: {a, b, op} -> {result, flags}.
// SUB reports borrow (a < b, unsigned) on carry.
module alu_8bit_golden_model
  import alu8_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [1:0]  op,
  output logic [7:0]  result,
  output alu8_flags_t flags
);

  logic [8:0] wide;

  always_comb begin
    wide           = '0;
    result         = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (op)
      OP_ADD: begin
        wide           = {1'b0, a} + {1'b0, b};
        result         = wide[7:0];
        flags.carry    = wide[8];
        flags.overflow = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is set exactly when a < b.
        wide           = {1'b0, a} - {1'b0, b};
        result         = wide[7:0];
        flags.carry    = wide[8];
        flags.overflow = (a[7] != b[7]) && (wide[7] != a[7]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: result = '0;
    endcase
    flags.zero = (result == 8'h00);
  end

endmodule

// File: rtl/alu_8bit_golden_checker.sv
// Monitor for the 8-bit ALU: delays each applied vector by the ALU latency, compares
// against the golden model, counts checks/mismatches, captures the first failure.
module alu_8bit_golden_checker
  import alu8_pkg::*;
#(
  parameter int unsigned DUT_LATENCY  = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ALARM_THRESH = 1,
  parameter logic [3:0]  CHECK_MASK   = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [1:0]       op,
  input  logic [7:0]       dut_result,
  input  logic             dut_carry,
  input  logic             dut_zero,
  input  logic             dut_overflow,
  input  logic             clear,
  output logic             check_valid,
  output logic             mismatch,
  output logic             alarm,
  output logic [CNT_W-1:0] vector_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             fail_valid,
  output logic [7:0]       fail_A,
  output logic [7:0]       fail_B,
  output logic [1:0]       fail_op,
  output logic [7:0]       fail_result
);

  localparam logic [CNT_W-1:0] Thresh = CNT_W'(ALARM_THRESH);

  alu8_vec_t   pipe_q [DUT_LATENCY];
  alu8_vec_t   tail;
  logic [7:0]  gold_result;
  alu8_flags_t gold_flags;
  logic [3:0]  diff;
  logic        miss;
  logic [CNT_W-1:0] vcnt_d, mcnt_d;

  assign tail = pipe_q[DUT_LATENCY-1];

  // Free-running delay line; rst/clear drop everything in flight, including this
  // cycle's input.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DUT_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: in_valid, a: A, b: B, op: op};
      for (int i = 1; i < DUT_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  alu_8bit_golden_model u_golden (
    .a      (tail.a),
    .b      (tail.b),
    .op     (tail.op),
    .result (gold_result),
    .flags  (gold_flags)
  );

  always_comb begin
    diff                = '0;
    diff[MASK_RESULT]   = (gold_result != dut_result);
    diff[MASK_CARRY]    = (gold_flags.carry != dut_carry);
    diff[MASK_ZERO]     = (gold_flags.zero != dut_zero);
    diff[MASK_OVERFLOW] = (gold_flags.overflow != dut_overflow);
  end

  assign miss = tail.valid && |(diff & CHECK_MASK);

  // Saturating counters.
  always_comb begin
    vcnt_d = vector_count;
    mcnt_d = mismatch_count;
    if (tail.valid && (vector_count != '1)) vcnt_d = vector_count + CNT_W'(1);
    if (miss && (mismatch_count != '1)) mcnt_d = mismatch_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      check_valid    <= 1'b0;
      mismatch       <= 1'b0;
      alarm          <= 1'b0;
      vector_count   <= '0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_A         <= '0;
      fail_B         <= '0;
      fail_op        <= '0;
      fail_result    <= '0;
    end else begin
      check_valid    <= tail.valid;
      mismatch       <= miss;
      vector_count   <= vcnt_d;
      mismatch_count <= mcnt_d;
      if (miss && (mcnt_d >= Thresh)) alarm <= 1'b1;
      if (miss && !fail_valid) begin
        fail_valid  <= 1'b1;
        fail_A      <= tail.a;
        fail_B      <= tail.b;
        fail_op     <= tail.op;
        fail_result <= dut_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit_golden_checker.sv
// Directed bench for the ALU golden checker; four instances cover the default,
// ALARM_THRESH=3, CNT_W=4 and CHECK_MASK=0 configurations on one shared stream.
module tb_alu_8bit_golden_checker;
  import alu8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [7:0] A = '0, B = '0, dut_result = '0;
  logic [1:0] op = '0;
  logic dut_carry = 1'b0, dut_zero = 1'b0, dut_overflow = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // d_: defaults, t_: ALARM_THRESH=3, c_: CNT_W=4, m_: CHECK_MASK=0
  logic d_cv, d_mm, d_al, d_fv; logic [15:0] d_vc, d_mc;
  logic [7:0] d_fa, d_fb, d_fr; logic [1:0] d_fo;
  logic t_cv, t_mm, t_al, t_fv; logic [15:0] t_vc, t_mc;
  logic [7:0] t_fa, t_fb, t_fr; logic [1:0] t_fo;
  logic c_cv, c_mm, c_al, c_fv; logic [3:0] c_vc, c_mc;
  logic [7:0] c_fa, c_fb, c_fr; logic [1:0] c_fo;
  logic m_cv, m_mm, m_al, m_fv; logic [15:0] m_vc, m_mc;
  logic [7:0] m_fa, m_fb, m_fr; logic [1:0] m_fo;

  alu_8bit_golden_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .clear(clear), .check_valid(d_cv), .mismatch(d_mm),
    .alarm(d_al), .vector_count(d_vc), .mismatch_count(d_mc), .fail_valid(d_fv),
    .fail_A(d_fa), .fail_B(d_fb), .fail_op(d_fo), .fail_result(d_fr)
  );

  alu_8bit_golden_checker #(.ALARM_THRESH(3)) dut_t3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .clear(clear), .check_valid(t_cv), .mismatch(t_mm),
    .alarm(t_al), .vector_count(t_vc), .mismatch_count(t_mc), .fail_valid(t_fv),
    .fail_A(t_fa), .fail_B(t_fb), .fail_op(t_fo), .fail_result(t_fr)
  );

  alu_8bit_golden_checker #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .clear(clear), .check_valid(c_cv), .mismatch(c_mm),
    .alarm(c_al), .vector_count(c_vc), .mismatch_count(c_mc), .fail_valid(c_fv),
    .fail_A(c_fa), .fail_B(c_fb), .fail_op(c_fo), .fail_result(c_fr)
  );

  alu_8bit_golden_checker #(.CHECK_MASK(4'b0000)) dut_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .clear(clear), .check_valid(m_cv), .mismatch(m_mm),
    .alarm(m_al), .vector_count(m_vc), .mismatch_count(m_mc), .fail_valid(m_fv),
    .fail_A(m_fa), .fail_B(m_fb), .fail_op(m_fo), .fail_result(m_fr)
  );

  // Bench-side ALU used only to build correct DUT responses: {r, c, z, v}.
  function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] o);
    logic [7:0] r; logic c, v;
    c = 1'b0; v = 1'b0;
    case (o)
      2'b00: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
      2'b01: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r, c, (r == 8'h00), v};
  endfunction

  // One cycle: apply a vector and present the ALU response to the previous one.
  task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] o, input logic [10:0] resp);
    in_valid = iv; A = a; B = b; op = o;
    {dut_result, dut_carry, dut_zero, dut_overflow} = resp;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'b00, '0);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'h12, 8'h34, OP_ADD, '0);
    drive(1'b1, 8'h56, 8'h78, OP_SUB, '0);
    n_checks++; if (d_cv !== 1'b0) begin n_fail++; $display("FAIL rst_check_valid got %b want 0", d_cv); end
    n_checks++; if (d_mm !== 1'b0) begin n_fail++; $display("FAIL rst_mismatch got %b want 0", d_mm); end
    n_checks++; if (d_al !== 1'b0) begin n_fail++; $display("FAIL rst_alarm got %b want 0", d_al); end
    n_checks++; if (d_vc !== 16'd0) begin n_fail++; $display("FAIL rst_vcount got %0h want 0", d_vc); end
    n_checks++; if (d_mc !== 16'd0) begin n_fail++; $display("FAIL rst_mcount got %0h want 0", d_mc); end
    n_checks++; if ({d_fv, d_fa, d_fb, d_fo, d_fr} !== 27'd0) begin
      n_fail++; $display("FAIL rst_capture got %0h want 0", {d_fv, d_fa, d_fb, d_fo, d_fr}); end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, '0);
    drive(1'b0, 8'h00, 8'h00, 2'b00, '0);
    n_checks++; if (d_cv !== 1'b0 || d_vc !== 16'd0) begin
      n_fail++; $display("FAIL rst_no_spurious got cv=%b vc=%0h want 0/0", d_cv, d_vc); end
  endtask

  task automatic test_add();
    drive(1'b1, 8'hFF, 8'hFF, OP_ADD, '0);
    drive(1'b0, 8'h00, 8'h00, 2'b00, {8'hFE, 3'b100});
    n_checks++; if (d_cv !== 1'b1) begin n_fail++; $display("FAIL add_check_valid got %b want 1", d_cv); end
    n_checks++; if (d_mm !== 1'b0) begin n_fail++; $display("FAIL add_mismatch got %b want 0", d_mm); end
    n_checks++; if (d_vc !== 16'd1) begin n_fail++; $display("FAIL add_vcount got %0h want 1", d_vc); end
    // 7F+01 = 80 with overflow; DUT reports v=0.
    drive(1'b1, 8'h7F, 8'h01, OP_ADD, '0);
    drive(1'b0, 8'h00, 8'h00, 2'b00, {8'h80, 3'b000});
    n_checks++; if (d_mm !== 1'b1) begin n_fail++; $display("FAIL addv_mismatch got %b want 1", d_mm); end
    n_checks++; if (d_al !== 1'b1) begin n_fail++; $display("FAIL addv_alarm got %b want 1", d_al); end
    n_checks++; if (d_mc !== 16'd1) begin n_fail++; $display("FAIL addv_mcount got %0h want 1", d_mc); end
    n_checks++; if ({d_fv, d_fa, d_fb, d_fo, d_fr} !== {1'b1, 8'h7F, 8'h01, 2'b00, 8'h80}) begin
      n_fail++; $display("FAIL addv_capture got %0h want %0h", {d_fv, d_fa, d_fb, d_fo, d_fr},
                         {1'b1, 8'h7F, 8'h01, 2'b00, 8'h80}); end
    // A second failure (01+01 reported as 03) must leave the capture alone.
    drive(1'b1, 8'h01, 8'h01, OP_ADD, '0);
    drive(1'b0, 8'h00, 8'h00, 2'b00, {8'h03, 3'b000});
    n_checks++; if (d_mc !== 16'd2) begin n_fail++; $display("FAIL add2_mcount got %0h want 2", d_mc); end
    n_checks++; if ({d_fa, d_fr} !== {8'h7F, 8'h80}) begin
      n_fail++; $display("FAIL add2_capture_held got %0h want 7f80", {d_fa, d_fr}); end
  endtask

  task automatic test_sub_logic();
    do_clear();
    n_checks++; if (d_al !== 1'b0 || d_vc !== 16'd0 || d_fv !== 1'b0) begin
      n_fail++; $display("FAIL clear_state got al=%b vc=%0h fv=%b want 0", d_al, d_vc, d_fv); end
    drive(1'b1, 8'hFF, 8'h01, OP_SUB, '0);
    drive(1'b1, 8'h00, 8'h01, OP_SUB, {8'hFE, 3'b000});
    drive(1'b1, 8'hAA, 8'h55, OP_AND, {8'hFF, 3'b100});
    drive(1'b1, 8'hAA, 8'h55, OP_OR,  {8'h00, 3'b010});
    drive(1'b1, 8'h80, 8'h01, OP_SUB, {8'hFF, 3'b000});
    drive(1'b0, 8'h00, 8'h00, 2'b00,  {8'h7F, 3'b001});
    n_checks++; if (d_cv !== 1'b1 || d_mm !== 1'b0) begin
      n_fail++; $display("FAIL subv_last got cv=%b mm=%b want 1/0", d_cv, d_mm); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, '0);
    n_checks++; if (d_vc !== 16'd5) begin n_fail++; $display("FAIL sublog_vcount got %0h want 5", d_vc); end
    n_checks++; if (d_mc !== 16'd0) begin n_fail++; $display("FAIL sublog_mcount got %0h want 0", d_mc); end
    n_checks++; if (d_cv !== 1'b0) begin n_fail++; $display("FAIL sublog_idle_cv got %b want 0", d_cv); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] g, pend;
    logic [7:0] a, b, a2, b2, r2;
    logic [1:0] o, o2;
    int t_cvs, t_mms, m_mms;
    pend = '0; a2 = '0; b2 = '0; r2 = '0; o2 = '0;
    t_cvs = 0; t_mms = 0; m_mms = 0;
    do_clear();
    for (int i = 1; i <= 11; i++) begin
      a = 8'(i * 37); b = 8'(i * 91 + 5); o = 2'(i);
      g = ref_alu(a, b, o);
      if (i == 2 || i == 5 || i == 9) g[3] = ~g[3];
      if (i == 2) begin a2 = a; b2 = b; o2 = o; r2 = g[10:3]; end
      drive(i <= 10, a, b, o, pend);
      pend = g;
      t_cvs += int'(t_cv); t_mms += int'(t_mm); m_mms += int'(m_mm);
      if (i == 9) begin
        n_checks++; if (t_al !== 1'b0) begin n_fail++; $display("FAIL b2b_alarm_early got %b want 0", t_al); end
      end
      if (i == 10) begin
        n_checks++; if (t_al !== 1'b1) begin n_fail++; $display("FAIL b2b_alarm_9th got %b want 1", t_al); end
      end
    end
    n_checks++; if (t_cvs != 10) begin n_fail++; $display("FAIL b2b_check_pulses got %0d want 10", t_cvs); end
    n_checks++; if (t_mms != 3) begin n_fail++; $display("FAIL b2b_mismatch_pulses got %0d want 3", t_mms); end
    n_checks++; if (t_vc !== 16'd10 || t_mc !== 16'd3) begin
      n_fail++; $display("FAIL b2b_counts got %0d/%0d want 10/3", t_vc, t_mc); end
    n_checks++; if ({t_fa, t_fb, t_fo, t_fr} !== {a2, b2, o2, r2}) begin
      n_fail++; $display("FAIL b2b_capture got %0h want %0h", {t_fa, t_fb, t_fo, t_fr}, {a2, b2, o2, r2}); end
    n_checks++; if (m_mms != 0 || m_mc !== 16'd0 || m_al !== 1'b0 || m_fv !== 1'b0) begin
      n_fail++; $display("FAIL mask0_quiet got pulses=%0d mc=%0h al=%b fv=%b want 0", m_mms, m_mc, m_al, m_fv); end
    n_checks++; if (m_vc !== 16'd10) begin n_fail++; $display("FAIL mask0_vcount got %0d want 10", m_vc); end
    n_checks++; if (d_al !== 1'b1) begin n_fail++; $display("FAIL b2b_default_alarm got %b want 1", d_al); end
  endtask

  task automatic test_midstream(input bit use_rst);
    int cvs;
    cvs = 0;
    do_clear();
    drive(1'b1, 8'h11, 8'h22, OP_ADD, '0);
    drive(1'b1, 8'h05, 8'h03, OP_SUB, {8'h00, 3'b010});  // v1 answered wrong
    n_checks++; if (d_al !== 1'b1) begin
      n_fail++; $display("FAIL mid_%s_pre_alarm got %b want 1", use_rst ? "rst" : "clr", d_al); end
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    drive(1'b1, 8'h40, 8'h40, OP_OR, {8'h00, 3'b010});   // v2 wrong, v3 applied
    rst = 1'b0; clear = 1'b0;
    n_checks++; if ({d_cv, d_mm, d_al, d_fv} !== 4'b0000 || d_vc !== 16'd0 || d_mc !== 16'd0) begin
      n_fail++; $display("FAIL mid_%s_cleared got cv=%b mm=%b al=%b fv=%b vc=%0h mc=%0h want 0",
                         use_rst ? "rst" : "clr", d_cv, d_mm, d_al, d_fv, d_vc, d_mc); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, {8'hFF, 3'b111});
    cvs += int'(d_cv);
    drive(1'b0, 8'h00, 8'h00, 2'b00, '0);
    cvs += int'(d_cv);
    n_checks++; if (cvs != 0 || d_mc !== 16'd0 || d_fv !== 1'b0) begin
      n_fail++; $display("FAIL mid_%s_dropped got cv_pulses=%0d mc=%0h fv=%b want 0",
                         use_rst ? "rst" : "clr", cvs, d_mc, d_fv); end
  endtask

  task automatic test_saturate();
    logic [10:0] g, pend;
    pend = '0;
    do_clear();
    for (int i = 1; i <= 21; i++) begin
      g = ref_alu(8'(i), 8'(i), OP_ADD);
      g[2] = ~g[2];
      drive(i <= 20, 8'(i), 8'(i), OP_ADD, pend);
      pend = g;
      if (i == 17) begin
        n_checks++; if (c_vc !== 4'hF || c_mc !== 4'hF) begin
          n_fail++; $display("FAIL sat_at16 got %0h/%0h want f/f", c_vc, c_mc); end
      end
    end
    n_checks++; if (c_vc !== 4'hF || c_mc !== 4'hF) begin
      n_fail++; $display("FAIL sat_final got %0h/%0h want f/f", c_vc, c_mc); end
    n_checks++; if (c_fa !== 8'h01 || c_al !== 1'b1) begin
      n_fail++; $display("FAIL sat_capture got fa=%0h al=%b want 01/1", c_fa, c_al); end
    n_checks++; if (d_mc !== 16'd20 || d_vc !== 16'd20) begin
      n_fail++; $display("FAIL sat_wide_counts got %0d/%0d want 20/20", d_vc, d_mc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_logic();
    test_back_to_back();
    test_midstream(1'b0);
    test_midstream(1'b1);
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
